bsg_manycore_proc_sync_unit: RTL

- Per-tile synchronisation unit sitting between the multi-hart core, the manycore endpoint and the banked dmem crossbar.
- Tracks up to num_harts_p load-reserved (LR) reservations, cleared by committed remote and local stores.
- Owns the remote-store credit counter and a per-tile fence state machine that stalls the requesting hart until all outstanding remote stores have drained.

---
 rtl/bsg_manycore_proc_sync_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_proc_sync_unit.sv
// Per-tile synchronisation unit: LR reservation table, remote-store credit
// counter and fence state machine shared by all harts of one tile.

// One reservation entry: a valid bit plus the reserved word address.
module bsg_manycore_proc_sync_resv_entry #(
    parameter int addr_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    set_i,
    input  logic [addr_width_p-1:0] set_addr_i,
    input  logic                    remote_clr_v_i,
    input  logic [addr_width_p-1:0] remote_addr_i,
    input  logic                    local_clr_v_i,
    input  logic [addr_width_p-1:0] local_addr_i,
    input  logic                    sc_clr_i,
    output logic                    v_o,
    output logic [addr_width_p-1:0] addr_o
);

    logic clr;

    // Remote, local and SC clears simply OR together; matching is against
    // the stored address, so an invalid entry is unaffected by a clear.
    assign clr = (remote_clr_v_i && (addr_o == remote_addr_i))
              || (local_clr_v_i  && (addr_o == local_addr_i))
              || sc_clr_i;

    // Valid bit: a new LR always wins over any clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i)    v_o <= 1'b0;
        else if (set_i) v_o <= 1'b1;
        else if (clr)   v_o <= 1'b0;
    end

    // Reserved address only changes when a new LR lands.
    always_ff @(posedge clk_i) begin
        if (reset_i)    addr_o <= '0;
        else if (set_i) addr_o <= set_addr_i;
    end

endmodule

module bsg_manycore_proc_sync_unit #(
    parameter int addr_width_p      = 32,
    parameter int num_harts_p       = 1,
    parameter int max_out_credits_p = 200,
    localparam int hart_id_width_lp = (num_harts_p > 1) ? $clog2(num_harts_p) : 1,
    localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        lr_v_i,
    input  logic [hart_id_width_lp-1:0] lr_hart_i,
    input  logic [addr_width_p-1:0]     lr_addr_i,

    input  logic                        sc_v_i,
    input  logic [hart_id_width_lp-1:0] sc_hart_i,
    output logic                        sc_success_o,

    input  logic                        in_v_i,
    input  logic                        in_yumi_i,
    input  logic [addr_width_p-1:0]     in_addr_i,

    input  logic                        lw_v_i,
    input  logic [hart_id_width_lp-1:0] lw_hart_i,
    input  logic [addr_width_p-1:0]     lw_addr_i,

    output logic [num_harts_p-1:0]      resv_v_o,

    input  logic                        out_launch_i,
    input  logic                        credit_return_i,
    output logic [credit_width_lp-1:0]  credits_o,
    output logic                        credit_avail_o,
    output logic                        outstanding_o,

    input  logic                        fence_req_i,
    output logic                        fence_stall_o,
    output logic                        fence_done_o,

    output logic                        error_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    // ---------------- reservation table ----------------
    logic [num_harts_p-1:0]                   set_vec, lw_clr_vec, sc_clr_vec;
    logic [num_harts_p-1:0][addr_width_p-1:0] resv_addr;
    logic                                     remote_clr_v;

    assign remote_clr_v = in_v_i & in_yumi_i;

    // Per-hart decode of LR/SC/local-store events; SC success reads the
    // registered valid bit, so same-cycle clears never affect it.
    always_comb begin
        set_vec      = '0;
        lw_clr_vec   = '0;
        sc_clr_vec   = '0;
        sc_success_o = 1'b0;
        for (int i = 0; i < num_harts_p; i++) begin
            if (lr_v_i && (lr_hart_i == hart_id_width_lp'(i))) set_vec[i] = 1'b1;
            if (lw_v_i && (lw_hart_i != hart_id_width_lp'(i))) lw_clr_vec[i] = 1'b1;
            if (sc_v_i && (sc_hart_i == hart_id_width_lp'(i))) begin
                sc_clr_vec[i] = 1'b1;
                sc_success_o  = resv_v_o[i];
            end
        end
    end

    for (genvar h = 0; h < num_harts_p; h++) begin : g_resv
        bsg_manycore_proc_sync_resv_entry #(
            .addr_width_p(addr_width_p)
        ) entry (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .set_i         (set_vec[h]),
            .set_addr_i    (lr_addr_i),
            .remote_clr_v_i(remote_clr_v),
            .remote_addr_i (in_addr_i),
            .local_clr_v_i (lw_clr_vec[h]),
            .local_addr_i  (lw_addr_i),
            .sc_clr_i      (sc_clr_vec[h]),
            .v_o           (resv_v_o[h]),
            .addr_o        (resv_addr[h])
        );
    end

    // ---------------- credit counter ----------------
    logic credit_dec, credit_inc, underflow, overflow;

    assign credit_dec = out_launch_i & ~credit_return_i;
    assign credit_inc = credit_return_i & ~out_launch_i;
    assign underflow  = credit_dec & (credits_o == '0);
    assign overflow   = credit_inc & (credits_o == max_credits_lp);

    // Count holds on an illegal step; the error flag is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_o <= max_credits_lp;
            error_o   <= 1'b0;
        end else begin
            if (credit_dec && !underflow)     credits_o <= credits_o - credit_width_lp'(1);
            else if (credit_inc && !overflow) credits_o <= credits_o + credit_width_lp'(1);
            if (underflow || overflow)        error_o   <= 1'b1;
        end
    end

    assign credit_avail_o = (credits_o != '0);
    assign outstanding_o  = (credits_o != max_credits_lp);

    // ---------------- fence FSM ----------------
    typedef enum logic [1:0] {e_idle, e_drain, e_done} fence_state_e;
    fence_state_e state_r, state_n;

    // State register; reset aborts any fence in flight without a done pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // Next state: DRAIN waits on the registered count, so a launch during
    // the drain simply extends it.
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle:  if (fence_req_i) state_n = outstanding_o ? e_drain : e_done;
            e_drain: if (!outstanding_o) state_n = e_done;
            e_done:  state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        fence_stall_o = (state_r == e_drain);
        fence_done_o  = (state_r == e_done);
    end

endmodule
